// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-aware arbiter that shares one UART transmitter between
// up to four valid/ready byte requesters, pacing itself on the UART's ready.
module uart_tx_arbiter #(
    parameter int          N_REQ        = 2,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           uart_data,
    output logic                 uart_en,
    input  logic                 uart_rdy,
    output logic [1:0]           owner,
    output logic                 locked,
    output logic                 busy,
    output logic                 lock_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [1:0]  grant_idx;
    logic        grant_valid;
    logic        grant_last;
    logic [7:0]  grant_data;
    logic        owner_valid;
    logic        transfer;

    always_comb begin
        owner_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (2'(i) == owner) owner_valid = req_valid[i];
        end
    end

    // Descending search so the smallest rotation offset from owner+1 wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner;
        if (locked) begin
            grant_valid = owner_valid;
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == (int'(owner) + k) % N_REQ && req_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = 2'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = 8'h00;
        grant_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == 2'(i)) begin
                grant_data = req_data[8*i +: 8];
                grant_last = req_last[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst && (state_reg == IDLE) && grant_valid
                                   && (grant_idx == 2'(gi));
        end
    endgenerate

    assign transfer = |(req_ready & req_valid);
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            uart_en      <= 1'b0;
            uart_data    <= 8'h00;
            owner        <= 2'(N_REQ - 1);
            locked       <= 1'b0;
            lock_timeout <= 1'b0;
            cnt_reg      <= 16'd0;
        end else begin
            uart_en      <= 1'b0;
            lock_timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (transfer) begin
                        uart_data <= grant_data;
                        owner     <= grant_idx;
                        locked    <= ~grant_last;
                        cnt_reg   <= 16'd0;
                        uart_en   <= 1'b1;
                        state_reg <= ISSUE;
                    end else if (!locked) begin
                        cnt_reg <= 16'd0;
                    end else if (!owner_valid) begin
                        if (cnt_reg == LOCK_TIMEOUT) begin
                            locked       <= 1'b0;
                            lock_timeout <= 1'b1;
                            cnt_reg      <= 16'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
                ISSUE:     state_reg <= WAIT_BUSY;
                WAIT_BUSY: if (!uart_rdy) state_reg <= WAIT_DONE;
                WAIT_DONE: if (uart_rdy) state_reg <= IDLE;
                default:   state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters, a short lock timeout
// and a simple UART model whose frame length can be changed per scenario.
module tb_uart_tx_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_data;
    logic           uart_en;
    logic           uart_rdy = 1'b1;
    logic [1:0]     owner;
    logic           locked;
    logic           busy;
    logic           lock_timeout;

    int checks = 0;
    int failures = 0;
    int frame_len = 20;
    int frame_cnt = 0;
    int ready_busy_viol = 0;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(16'd20)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
        .uart_en(uart_en), .uart_rdy(uart_rdy), .owner(owner), .locked(locked),
        .busy(busy), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // UART model: ready drops the cycle after the enable pulse and stays low
    // for frame_len cycles; it ignores the arbiter's reset.
    always @(posedge clk) begin
        if (uart_en) begin
            uart_rdy  <= 1'b0;
            frame_cnt <= frame_len;
        end else if (frame_cnt > 1) begin
            frame_cnt <= frame_cnt - 1;
        end else begin
            frame_cnt <= 0;
            uart_rdy  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && busy && req_ready != '0) ready_busy_viol <= ready_busy_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Waits for a grant, checks who got it, then checks the ISSUE cycle.
    task automatic grant(input string tag, input logic [N-1:0] exp_ready,
                         input logic [7:0] exp_byte, input logic [1:0] exp_owner,
                         input logic exp_locked);
        int n;
        #1;
        n = 0;
        while (req_ready == '0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
        chk({tag, "_en"}, 32'(uart_en), 32'd1);
        chk({tag, "_data"}, 32'(uart_data), 32'(exp_byte));
        chk({tag, "_owner"}, 32'(owner), 32'(exp_owner));
        chk({tag, "_locked"}, 32'(locked), 32'(exp_locked));
    endtask

    initial begin
        int pulse_n;
        int grant_n;
        int extra_en;
        int extra_rdy;
        int idle_seen;

        // Reset state, with a request presented to show ready is held off.
        req_valid = 2'b01;
        req_last = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_en", 32'(uart_en), 32'd0);
        chk("rst_data", 32'(uart_data), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(lock_timeout), 32'd0);
        req_valid = '0;
        rst = 1'b0;

        // Single byte from requester 0.
        @(negedge clk);
        req_data[7:0] = 8'h41;
        req_last = 2'b01;
        req_valid = 2'b01;
        grant("single", 2'b01, 8'h41, 2'd0, 1'b0);
        req_valid = '0;
        @(negedge clk);
        chk("single_en_pulse", 32'(uart_en), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        wait_idle("single", 100);

        // Round-robin between two continuously valid single-byte requesters.
        do_reset();
        req_data = {8'hB1, 8'hA0};
        req_last = 2'b11;
        req_valid = 2'b11;
        grant("rr0", 2'b01, 8'hA0, 2'd0, 1'b0);
        wait_idle("rr0", 100);
        grant("rr1", 2'b10, 8'hB1, 2'd1, 1'b0);
        wait_idle("rr1", 100);
        grant("rr2", 2'b01, 8'hA0, 2'd0, 1'b0);
        wait_idle("rr2", 100);
        grant("rr3", 2'b10, 8'hB1, 2'd1, 1'b0);
        wait_idle("rr3", 100);

        // Three-byte packet from requester 0 with requester 1 waiting.
        do_reset();
        req_data = {8'hB1, 8'h10};
        req_last = 2'b10;
        req_valid = 2'b11;
        grant("pkt0", 2'b01, 8'h10, 2'd0, 1'b1);
        req_data[7:0] = 8'h11;
        wait_idle("pkt0", 100);
        grant("pkt1", 2'b01, 8'h11, 2'd0, 1'b1);
        req_data[7:0] = 8'h12;
        req_last = 2'b11;
        wait_idle("pkt1", 100);
        grant("pkt2", 2'b01, 8'h12, 2'd0, 1'b0);
        req_valid = 2'b10;
        wait_idle("pkt2", 100);
        grant("pkt3", 2'b10, 8'hB1, 2'd1, 1'b0);
        req_valid = '0;
        wait_idle("pkt3", 100);

        // Lock timeout: requester 0 leaves its packet open and goes quiet.
        do_reset();
        req_data = {8'h66, 8'h55};
        req_last = 2'b10;
        req_valid = 2'b11;
        grant("tmo_first", 2'b01, 8'h55, 2'd0, 1'b1);
        req_valid = 2'b10;
        wait_idle("tmo_first", 100);
        pulse_n = 0;
        grant_n = 0;
        for (int n = 1; n <= 60 && grant_n == 0; n++) begin
            #1;
            if (lock_timeout && pulse_n == 0) pulse_n = n;
            if (req_ready[1]) grant_n = n;
            if (grant_n == 0) @(negedge clk);
        end
        chk("tmo_pulse_window", 32'(pulse_n >= 20 && pulse_n <= 22), 32'd1);
        chk("tmo_grant_after", 32'(grant_n >= pulse_n && grant_n <= pulse_n + 1 && pulse_n != 0), 32'd1);
        @(negedge clk);
        chk("tmo_en", 32'(uart_en), 32'd1);
        chk("tmo_data", 32'(uart_data), 32'h66);
        chk("tmo_owner", 32'(owner), 32'd1);
        chk("tmo_pulse_once", 32'(lock_timeout), 32'd0);
        req_valid = '0;
        wait_idle("tmo", 100);

        // Handshake pacing with a 1000-cycle UART frame.
        do_reset();
        frame_len = 1000;
        req_data = {8'hB1, 8'hA0};
        req_last = 2'b11;
        req_valid = 2'b11;
        grant("pace0", 2'b01, 8'hA0, 2'd0, 1'b0);
        extra_en = 0;
        extra_rdy = 0;
        idle_seen = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (uart_en) extra_en++;
            if (req_ready != '0) extra_rdy++;
            if (!busy) idle_seen++;
        end
        chk("pace_no_en", 32'(extra_en), 32'd0);
        chk("pace_no_ready", 32'(extra_rdy), 32'd0);
        chk("pace_busy", 32'(idle_seen), 32'd0);
        grant("pace1", 2'b10, 8'hB1, 2'd1, 1'b0);
        req_valid = '0;
        wait_idle("pace1", 1100);

        // Reset while waiting for the frame to finish.
        frame_len = 50;
        @(negedge clk);
        req_data[7:0] = 8'h77;
        req_last = 2'b00;
        req_valid = 2'b01;
        grant("wd0", 2'b01, 8'h77, 2'd0, 1'b1);
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("wd_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("wd_rst_busy", 32'(busy), 32'd0);
        chk("wd_rst_owner", 32'(owner), 32'd1);
        chk("wd_rst_locked", 32'(locked), 32'd0);
        chk("wd_rst_data", 32'(uart_data), 32'd0);
        chk("wd_rst_en", 32'(uart_en), 32'd0);
        rst = 1'b0;
        req_data[15:8] = 8'h99;
        req_last = 2'b10;
        req_valid = 2'b10;
        grant("wd1", 2'b10, 8'h99, 2'd1, 1'b0);
        req_valid = '0;
        wait_idle("wd1", 200);

        chk("ready_only_idle", 32'(ready_busy_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
